// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word/byte widths, memory access unit state encoding
// and the byte-lane helpers used for both write splitting and read assembly.
package cpu_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    RD_CAP = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Byte of a word that lives at address (upper_addr=0) or address+1 (upper_addr=1).
  function automatic logic [BYTE_WIDTH-1:0] lane_byte(
    input logic [WORD_WIDTH-1:0] word,
    input logic                  little_endian,
    input logic                  upper_addr
  );
    return (little_endian ^ upper_addr) ? word[BYTE_WIDTH-1:0]
                                        : word[WORD_WIDTH-1:BYTE_WIDTH];
  endfunction

  function automatic logic [WORD_WIDTH-1:0] assemble_word(
    input logic [BYTE_WIDTH-1:0] first_byte,
    input logic [BYTE_WIDTH-1:0] second_byte,
    input logic                  little_endian
  );
    return little_endian ? {second_byte, first_byte} : {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Splits 16-bit CPU word accesses into two byte accesses on a byte-wide memory
// with registered read data; one request in flight, response held until consumed.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int MEM_BYTES     = 16384,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [BYTE_WIDTH-1:0] mem_rdata
);

  localparam int unsigned LAST_START = MEM_BYTES - 2;

  state_t                state_reg;
  logic [WORD_WIDTH-1:0] addr_reg;
  logic [WORD_WIDTH-1:0] wdata_reg;
  logic [BYTE_WIDTH-1:0] first_byte_reg;
  logic                  addr_bad;

  assign req_ready = (state_reg == IDLE) && !reset;
  // A word starting on the last byte (or beyond) would straddle the end of memory.
  assign addr_bad  = 32'(req_addr) > LAST_START;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      first_byte_reg <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
    end else begin
      // Memory-side outputs are only live for one state at a time.
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            if (addr_bad) begin
              state_reg <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_write) begin
              state_reg <= WR_LO;
              mem_addr  <= req_addr;
              mem_we    <= 1'b1;
              mem_wdata <= lane_byte(req_wdata, LITTLE_ENDIAN, 1'b0);
            end else begin
              state_reg <= RD_LO;
              mem_addr  <= req_addr;
            end
          end
        end
        RD_LO: begin
          state_reg <= RD_HI;
          mem_addr  <= addr_reg + 1'b1;
        end
        RD_HI: begin
          // Data for the first address arrives one cycle after it was presented.
          first_byte_reg <= mem_rdata;
          state_reg      <= RD_CAP;
        end
        RD_CAP: begin
          state_reg <= DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= assemble_word(first_byte_reg, mem_rdata, LITTLE_ENDIAN);
        end
        WR_LO: begin
          state_reg <= WR_HI;
          mem_addr  <= addr_reg + 1'b1;
          mem_we    <= 1'b1;
          mem_wdata <= lane_byte(wdata_reg, LITTLE_ENDIAN, 1'b1);
        end
        WR_HI: begin
          state_reg <= DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        DONE: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Drives a little-endian and a big-endian instance with identical requests, each
// attached to its own byte memory model, and compares against hand-computed values.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, rsp_ready;
  logic [15:0] req_addr, req_wdata;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_we0;
  logic [15:0] rsp_rdata0, mem_addr0;
  logic [7:0]  mem_wdata0, mem_rdata0;
  logic        req_ready1, rsp_valid1, rsp_err1, mem_we1;
  logic [15:0] rsp_rdata1, mem_addr1;
  logic [7:0]  mem_wdata1, mem_rdata1;

  logic [7:0] mem0 [0:16383];
  logic [7:0] mem1 [0:16383];
  int we_cnt0, we_cnt1;
  logic bd_copy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.MEM_BYTES(16384), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0)
  );

  mem_access_unit #(.MEM_BYTES(16384), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
  );

  always @(posedge clock) begin
    if (mem_we0) begin
      mem0[mem_addr0[13:0]] <= mem_wdata0;
      we_cnt0 <= we_cnt0 + 1;
    end
    mem_rdata0 <= mem0[mem_addr0[13:0]];
  end

  // The copy port lets the big-endian instance read bytes laid down little-endian.
  always @(posedge clock) begin
    if (mem_we1) begin
      mem1[mem_addr1[13:0]] <= mem_wdata1;
      we_cnt1 <= we_cnt1 + 1;
    end
    if (bd_copy) begin
      mem1[16] <= mem0[16];
      mem1[17] <= mem0[17];
    end
    mem_rdata1 <= mem1[mem_addr1[13:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // b0/b1: bytes expected at addr/addr+1 in the little-endian memory after a write.
  typedef struct {
    bit          w;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          err;
    logic [15:0] rdata;
    int          lat;
    int          we;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int we0_start;
    int we1_start;
    logic [15:0] a1;
    a1 = v.addr + 16'd1;
    @(negedge clock);
    chk("vec_req_ready", req_ready0, 1);
    we0_start = we_cnt0;
    we1_start = we_cnt1;
    req_valid = 1'b1; req_write = v.w; req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b0;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid0 && lat < 20);
    chk("vec_latency", lat, v.lat);
    chk("vec_rsp_valid_be", rsp_valid1, 1);
    chk("vec_err_le", rsp_err0, v.err);
    chk("vec_err_be", rsp_err1, v.err);
    chk("vec_rdata_le", rsp_rdata0, v.rdata);
    chk("vec_rdata_be", rsp_rdata1, v.rdata);
    chk("vec_done_mem_we", mem_we0, 0);
    chk("vec_done_mem_addr", mem_addr0, 0);
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("vec_rsp_cleared", rsp_valid0, 0);
    chk("vec_we_pulses_le", we_cnt0 - we0_start, v.we);
    chk("vec_we_pulses_be", we_cnt1 - we1_start, v.we);
    if (v.w && !v.err) begin
      chk("vec_mem_le_lo", mem0[v.addr[13:0]], v.b0);
      chk("vec_mem_le_hi", mem0[a1[13:0]], v.b1);
      chk("vec_mem_be_lo", mem1[v.addr[13:0]], v.b1);
      chk("vec_mem_be_hi", mem1[a1[13:0]], v.b0);
    end
    $display("vec %0d: %s addr=0x%04h wdata=0x%04h -> err=%0d rdata=0x%04h/0x%04h lat=%0d",
             idx, v.w ? "WR" : "RD", v.addr, v.wdata, rsp_err0, v.rdata, v.rdata, lat);
  endtask

  logic [15:0] b2b_addr [4];
  logic [15:0] b2b_data [4];
  bit          b2b_w    [4];
  logic [15:0] b2b_exp  [4];

  initial begin
    int lat;
    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 3, 2, 8'hEF, 8'hBE};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 4, 0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 16'h3FFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 16'h3FFE, 16'hA55A, 1'b0, 16'h0000, 3, 2, 8'h5A, 8'hA5};
    vecs[4] = '{1'b0, 16'h3FFE, 16'h0000, 1'b0, 16'hA55A, 4, 0, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 1, 0, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 16'h4000, 16'h0000, 1'b1, 16'h0000, 1, 0, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 16'h0100, 16'h00FF, 1'b0, 16'h0000, 3, 2, 8'hFF, 8'h00};
    vecs[8] = '{1'b0, 16'h0100, 16'h0000, 1'b0, 16'h00FF, 4, 0, 8'h00, 8'h00};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; bd_copy = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready_le", req_ready0, 0);
    chk("rst_req_ready_be", req_ready1, 0);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_req_ready", req_ready0, 1);
    $display("reset: req_ready=%0d rsp_valid=%0d", req_ready0, rsp_valid0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Same bytes read by both byte orders.
    @(negedge clock);
    bd_copy = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bd_copy = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid0 && lat < 20);
    chk("order_latency", lat, 4);
    chk("order_rdata_le", rsp_rdata0, 16'hBEEF);
    chk("order_rdata_be", rsp_rdata1, 16'hEFBE);
    $display("order: le=0x%04h be=0x%04h", rsp_rdata0, rsp_rdata1);

    // Response held 5 cycles with a stray request pulse in the middle.
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid0, 1);
      chk("hold_rdata_le", rsp_rdata0, 16'hBEEF);
      chk("hold_rdata_be", rsp_rdata1, 16'hEFBE);
      chk("hold_req_ready", req_ready0, 0);
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050; req_wdata = 16'h7777;
      end
      if (i == 2) req_valid = 1'b0;
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("hold_release", rsp_valid0, 0);
    repeat (3) @(negedge clock);
    chk("hold_no_stray_rsp", rsp_valid0, 0);
    chk("hold_no_stray_we", mem_we0, 0);
    chk("hold_idle_ready", req_ready0, 1);
    $display("hold: stray request ignored, req_ready=%0d", req_ready0);

    // Reset while the second byte of a write is being driven.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_in_wr_hi", mem_we0, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_rsp_valid", rsp_valid0, 0);
    chk("abort_req_ready", req_ready0, 0);
    chk("abort_mem_we", mem_we0, 0);
    chk("abort_mem_addr", mem_addr0, 0);
    chk("abort_mem_wdata", mem_wdata0, 0);
    chk("abort_rsp_err", rsp_err0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_no_rsp", rsp_valid0, 0);
    chk("abort_mem_le", mem0[16'h0020], 8'h34);
    chk("abort_mem_be", mem1[16'h0020], 8'h12);
    $display("abort: mem_le[0x20]=0x%02h mem_be[0x20]=0x%02h", mem0[16'h0020], mem1[16'h0020]);

    // Back-to-back traffic with rsp_ready tied high.
    b2b_w[0] = 1'b1; b2b_addr[0] = 16'h0000; b2b_data[0] = 16'h0001; b2b_exp[0] = 16'h0000;
    b2b_w[1] = 1'b1; b2b_addr[1] = 16'h0002; b2b_data[1] = 16'h0002; b2b_exp[1] = 16'h0000;
    b2b_w[2] = 1'b0; b2b_addr[2] = 16'h0000; b2b_data[2] = 16'h0000; b2b_exp[2] = 16'h0001;
    b2b_w[3] = 1'b0; b2b_addr[3] = 16'h0002; b2b_data[3] = 16'h0000; b2b_exp[3] = 16'h0002;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_req_ready", req_ready0, 1);
      req_valid = 1'b1; req_write = b2b_w[i]; req_addr = b2b_addr[i]; req_wdata = b2b_data[i];
      @(posedge clock);
      lat = 0;
      do begin
        @(negedge clock);
        req_valid = 1'b0;
        lat++;
      end while (!rsp_valid0 && lat < 20);
      chk("b2b_latency", lat, b2b_w[i] ? 3 : 4);
      chk("b2b_rdata_le", rsp_rdata0, b2b_exp[i]);
      chk("b2b_rdata_be", rsp_rdata1, b2b_exp[i]);
      $display("b2b %0d: %s addr=0x%04h rdata=0x%04h lat=%0d",
               i, b2b_w[i] ? "WR" : "RD", b2b_addr[i], rsp_rdata0, lat);
      @(negedge clock);
    end
    rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
